// File: rtl/easy_cpu_debug_jtag_pkg.sv
// Shared definitions for the debug-slave virtual-JTAG driver.
// Latency: n/a (types, constants and a latency helper only).
// Backpressure: n/a.
package easy_cpu_debug_jtag_pkg;

    // Sequence walked for every command. The state only advances on a tck fall,
    // except for the IDLE->UIR accept and the single-cycle DONE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_DONE
    } jtag_state_t;

    // Virtual IR codes understood by the debug slave.
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // tck periods per command: UIR + CDR + UDR, one per DR bit, plus run-test-idle.
    function automatic int n_tck(input int dr_width, input int rti_tcks);
        return 3 + dr_width + rti_tcks;
    endfunction

endpackage

// File: rtl/easy_cpu_debug_tck_gen.sv
// tck generator: divides clk by 2*TCK_DIV while run is high, parks tck low otherwise.
// Latency: first rise TCK_DIV clk edges after run rises; rise/fall strobes lead the edge that moves tck.
// Backpressure: none; run low clears the divider and tck on the next edge.
//
// Ports: clk, reset_n (sync, active-low), run (enable), tck (registered clock out),
//        rise/fall (combinational strobes, high in the cycle whose closing edge sets/clears tck).
module easy_cpu_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             term;

    assign term = run && (div_q == DIV_LAST);
    assign rise = term && !tck;
    assign fall = term && tck;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
            tck   <= 1'b0;
        end else if (!run) begin
            div_q <= '0;
            tck   <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            tck   <= ~tck;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/easy_cpu_debug_jtag_driver.sv
// Virtual-JTAG initiator: turns one IR+DR command into a UIR/CDR/SDR/UDR/RTI sequence, returns captured DR.
// Latency: rsp_valid 1 + 2*TCK_DIV*n_tck(DR_WIDTH,RTI_TCKS) clk edges after accept (173 with defaults).
// Backpressure: cmd_ready is high only in IDLE; commands presented while busy wait until then.
//
// Ports: clk, reset_n (sync, active-low); cmd_valid/cmd_ready/cmd_ir/cmd_data request side;
//        rsp_valid/rsp_data response pulse; vji_* drive the debug slave's virtual-JTAG port,
//        vji_tdo returns its serial data.
module easy_cpu_debug_jtag_driver
    import easy_cpu_debug_jtag_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CNT_MAX = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_TCKS - 1);

    jtag_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] tx_q, rx_q;
    logic                tck_run, tck_rise, tck_fall;
    logic                accept;

    // tck only runs between accept and DONE, so it sits low whenever the driver is idle.
    assign tck_run = (state_q != ST_IDLE) && (state_q != ST_DONE);

    easy_cpu_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (tck_run),
        .tck     (vji_tck),
        .rise    (tck_rise),
        .fall    (tck_fall)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Flags decode the registered state, which only moves on a fall (or at accept),
    // so each flag is held across its state's rises without extra registers.
    assign vji_uir = (state_q == ST_UIR);
    assign vji_cdr = (state_q == ST_CDR);
    assign vji_sdr = (state_q == ST_SDR);
    assign vji_udr = (state_q == ST_UDR);
    assign vji_rti = (state_q == ST_RTI);
    assign vji_tdi = vji_sdr && tx_q[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts completed tck periods inside SDR and RTI.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_UIR;
                    cnt_d   = '0;
                end
            end
            ST_UIR: begin
                if (tck_fall) state_d = ST_CDR;
            end
            ST_CDR: begin
                if (tck_fall) begin
                    state_d = ST_SDR;
                    cnt_d   = '0;
                end
            end
            ST_SDR: begin
                if (tck_fall) begin
                    if (cnt_q == SDR_LAST) begin
                        state_d = ST_UDR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_UDR: begin
                if (tck_fall) begin
                    state_d = ST_RTI;
                    cnt_d   = '0;
                end
            end
            ST_RTI: begin
                if (tck_fall) begin
                    if (cnt_q == RTI_LAST) state_d = ST_DONE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Data path: slave samples tdi on rise, so tdi is advanced on the fall that
    // ends each SDR period; tdo is captured on the SDR rise itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vji_ir_in <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                vji_ir_in <= cmd_ir;
                tx_q      <= cmd_data;
                rx_q      <= '0;
            end
            if ((state_q == ST_SDR) && tck_rise) begin
                rx_q <= {vji_tdo, rx_q[DR_WIDTH-1:1]};
            end
            if ((state_q == ST_SDR) && tck_fall) begin
                tx_q <= {1'b0, tx_q[DR_WIDTH-1:1]};
            end
            if (state_q == ST_DONE) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_easy_cpu_debug_jtag_driver.sv
// Bench for easy_cpu_debug_jtag_driver: default build (index 0) and TCK_DIV=1/RTI_TCKS=1 build (index 1).
// Each build talks to a small debug-slave model that shifts on tck rises.
// Latency: n/a. Backpressure: n/a.
module tb_easy_cpu_debug_jtag_driver;
    import easy_cpu_debug_jtag_pkg::*;

    localparam logic [37:0] CAP_WORD = 38'h2A_1234_5678;

    logic             clk;
    logic             reset_n;
    logic [1:0]       cmd_valid;
    logic [1:0][1:0]  cmd_ir;
    logic [1:0][37:0] cmd_data;
    wire  [1:0]       cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti;
    wire  [1:0][37:0] rsp_data;
    wire  [1:0][1:0]  ir_in;
    wire  [1:0]       tdo;

    // slave model state
    logic             load_jdo = 1'b0;
    logic [1:0]       tck_prev = 2'b00;
    logic [1:0][37:0] sr  = '0;
    logic [1:0][37:0] jdo = '0;
    logic [1:0][1:0]  m_ir = '0;
    int               n_uir [2] = '{0, 0};
    int               n_cdr [2] = '{0, 0};
    int               n_sdr [2] = '{0, 0};
    int               n_udr [2] = '{0, 0};
    int               n_rti [2] = '{0, 0};
    time              t_uir [2] = '{0, 0};
    time              t_cdr [2] = '{0, 0};
    int               viol = 0;

    int n_chk  = 0;
    int n_pass = 0;

    easy_cpu_debug_jtag_driver u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_ir(cmd_ir[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]), .vji_ir_in(ir_in[0]),
        .vji_uir(uir[0]), .vji_cdr(cdr[0]), .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0])
    );

    easy_cpu_debug_jtag_driver #(.TCK_DIV(1), .DR_WIDTH(38), .IR_WIDTH(2), .RTI_TCKS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_ir(cmd_ir[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]), .vji_ir_in(ir_in[1]),
        .vji_uir(uir[1]), .vji_cdr(cdr[1]), .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1])
    );

    always #5 clk = ~clk;

    // Outside SDR the slave drives tdo high; a driver sampling it there corrupts rsp.
    assign tdo = {sdr[1] ? sr[1][0] : 1'b1, sdr[0] ? sr[0][0] : 1'b1};

    // The model reacts one clk after each tck rise; flags and tdi are held for at
    // least that long, and the driver has already taken tdo at the rise itself.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            tck_prev[g] <= tck[g];
            if (tck[g] && !tck_prev[g]) begin
                if (uir[g]) begin
                    n_uir[g] <= n_uir[g] + 1;
                    m_ir[g]  <= ir_in[g];
                    t_uir[g] <= $time;
                end
                if (cdr[g]) begin
                    n_cdr[g] <= n_cdr[g] + 1;
                    sr[g]    <= load_jdo ? jdo[g] : CAP_WORD;
                    t_cdr[g] <= $time;
                end
                if (sdr[g]) begin
                    n_sdr[g] <= n_sdr[g] + 1;
                    sr[g]    <= {tdi[g], sr[g][37:1]};
                end
                if (udr[g]) begin
                    n_udr[g] <= n_udr[g] + 1;
                    jdo[g]   <= sr[g];
                end
                if (rti[g]) n_rti[g] <= n_rti[g] + 1;
            end
        end
    end

    // Flags mutually exclusive; tck low whenever the driver is idle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (($countones({uir[g], cdr[g], sdr[g], udr[g], rti[g]}) > 1) || (cmd_ready[g] && tck[g]))
                viol++;
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Presents a command and returns #1 after the accepting edge.
    task automatic start_cmd(input int i, input logic [1:0] ir, input logic [37:0] d, input bit hold);
        int w;
        @(negedge clk);
        cmd_ir[i]    = ir;
        cmd_data[i]  = d;
        cmd_valid[i] = 1'b1;
        w = 0;
        while (!cmd_ready[i] && w < 500) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid[i] = 1'b0;
    endtask

    // Counts edges from the accept to the rsp_valid pulse; bad counts cycles with ready high while busy.
    task automatic wait_rsp(input int i, output logic [37:0] rsp, output int lat, output int bad);
        lat = 0;
        bad = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!rsp_valid[i] && cmd_ready[i]) bad++;
        end while (!rsp_valid[i] && lat < 1000);
        rsp = rsp_data[i];
    endtask

    initial begin
        logic [37:0] rsp;
        logic [37:0] b2b_dat [3];
        logic [37:0] b2b_exp [3];
        int lat, bad, cnt;
        int b_uir, b_cdr, b_sdr, b_udr, b_rti;

        clk       = 1'b0;
        reset_n   = 1'b0;
        cmd_valid = '0;
        cmd_ir    = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 80'(cmd_ready), 80'(2'b11));
        check("rst_vji", 80'({tck, tdi, uir, cdr, sdr, udr, rti, ir_in}), 80'(0));
        check("rst_rsp", 80'({rsp_valid, rsp_data}), 80'(0));
        reset_n = 1'b1;

        // single command, default build
        b_uir = n_uir[0]; b_cdr = n_cdr[0]; b_sdr = n_sdr[0]; b_udr = n_udr[0]; b_rti = n_rti[0];
        start_cmd(0, IR_BREAK, 38'h15_DEAD_BEEF, 1'b0);
        wait_rsp(0, rsp, lat, bad);
        check("s1_rsp", 80'(rsp), 80'(CAP_WORD));
        check("s1_lat", 80'(lat), 80'(173));
        check("s1_busy_ready", 80'(bad), 80'(0));
        @(posedge clk);
        #1;
        check("s1_rsp_pulse", 80'(rsp_valid[0]), 80'(0));
        check("s1_jdo", 80'(jdo[0]), 80'(38'h15_DEAD_BEEF));
        check("s1_ir", 80'(m_ir[0]), 80'(IR_BREAK));
        check("s1_rise_uir", 80'(n_uir[0] - b_uir), 80'(1));
        check("s1_rise_cdr", 80'(n_cdr[0] - b_cdr), 80'(1));
        check("s1_rise_sdr", 80'(n_sdr[0] - b_sdr), 80'(38));
        check("s1_rise_udr", 80'(n_udr[0] - b_udr), 80'(1));
        check("s1_rise_rti", 80'(n_rti[0] - b_rti), 80'(2));
        check("s1_tck_period", 80'(t_cdr[0] - t_uir[0]), 80'(40));

        // back-to-back with cmd_valid held; slave returns the previous jdo
        load_jdo   = 1'b1;
        b2b_dat[0] = 38'h0;            b2b_exp[0] = 38'h15_DEAD_BEEF;
        b2b_dat[1] = 38'h3F_FFFF_FFFF; b2b_exp[1] = 38'h0;
        b2b_dat[2] = 38'h1;            b2b_exp[2] = 38'h3F_FFFF_FFFF;
        start_cmd(0, IR_OCIMEM, b2b_dat[0], 1'b1);
        for (int j = 0; j < 3; j++) begin
            wait_rsp(0, rsp, lat, bad);
            check($sformatf("b2b%0d_rsp", j), 80'(rsp), 80'(b2b_exp[j]));
            check($sformatf("b2b%0d_lat", j), 80'(lat), 80'(173));
            check($sformatf("b2b%0d_busy_ready", j), 80'(bad), 80'(0));
            if (j < 2) begin
                cmd_data[0] = b2b_dat[j+1];
                @(posedge clk);
                #1;
                check($sformatf("b2b%0d_next_accept", j), 80'(cmd_ready[0]), 80'(0));
            end else begin
                cmd_valid[0] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle_after", 80'(cmd_ready[0]), 80'(1));
        check("b2b_jdo", 80'(jdo[0]), 80'(38'h1));
        load_jdo = 1'b0;

        // reset pulse 60 edges after an accept
        start_cmd(0, IR_TRACEMEM, 38'h03_0000_00FF, 1'b0);
        repeat (59) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_vji", 80'({tck[0], tdi[0], uir[0], cdr[0], sdr[0], udr[0], rti[0], ir_in[0]}), 80'(0));
        check("mid_rst_hs", 80'({cmd_ready[0], rsp_valid[0], rsp_data[0]}), 80'({1'b1, 1'b0, 38'h0}));
        reset_n = 1'b1;
        cnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0] || !cmd_ready[0]) cnt++;
        end
        check("mid_rst_quiet", 80'(cnt), 80'(0));
        start_cmd(0, IR_TRACECTRL, 38'h2A_AAAA_5555, 1'b0);
        wait_rsp(0, rsp, lat, bad);
        check("post_rst_rsp", 80'(rsp), 80'(CAP_WORD));
        check("post_rst_lat", 80'(lat), 80'(173));
        check("post_rst_jdo", 80'(jdo[0]), 80'(38'h2A_AAAA_5555));
        check("post_rst_ir", 80'(m_ir[0]), 80'(IR_TRACECTRL));

        // TCK_DIV=1, RTI_TCKS=1 build
        b_sdr = n_sdr[1]; b_rti = n_rti[1];
        start_cmd(1, IR_BREAK, 38'h15_DEAD_BEEF, 1'b0);
        wait_rsp(1, rsp, lat, bad);
        check("fast_rsp", 80'(rsp), 80'(CAP_WORD));
        check("fast_lat", 80'(lat), 80'(85));
        check("fast_busy_ready", 80'(bad), 80'(0));
        check("fast_jdo", 80'(jdo[1]), 80'(38'h15_DEAD_BEEF));
        check("fast_ir", 80'(m_ir[1]), 80'(IR_BREAK));
        check("fast_rise_sdr", 80'(n_sdr[1] - b_sdr), 80'(38));
        check("fast_rise_rti", 80'(n_rti[1] - b_rti), 80'(1));
        check("fast_tck_period", 80'(t_cdr[1] - t_uir[1]), 80'(20));

        check("flag_excl_tck_idle", 80'(viol), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/easy_cpu_debug_jtag_driver.md
Name: easy_cpu_debug_jtag_driver

Overview:
- On-chip initiator for the Nios II debug slave's virtual-JTAG side; it drives what the sld_virtual_jtag_basic hub would otherwise drive.
- Converts a system-clock command (IR code + 38-bit DR word) into a complete IR-update / capture / shift / update / run-test-idle sequence on vji_* signals.
- Returns the 38-bit captured DR to the requester.
- Used for self-hosted debug access and for closed-loop simulation of the debug slave.

Parameters:
- TCK_DIV, 2, clk cycles per tck half-period; legal range ≥1.
- DR_WIDTH, 38, shift-register length; must match the debug slave's jdo/sr width.
- IR_WIDTH, 2, virtual IR width.
- RTI_TCKS, 2, tck periods spent in run-test-idle after update; legal range ≥1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  driver idle, command accepted when valid&ready
- cmd_ir  in  IR_WIDTH  virtual IR code (00 ocimem, 01 tracemem, 10 break, 11 tracectrl)
- cmd_data  in  DR_WIDTH  word shifted into the slave, LSB first
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  DR_WIDTH  word shifted out of the slave, LSB first
- vji_tck  out  1  generated tck
- vji_tdi  out  1  serial data to the slave
- vji_tdo  in  1  serial data from the slave
- vji_ir_in  out  IR_WIDTH  virtual IR value
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state flags

Behaviour:
- All sequential logic is on clk; reset is synchronous, active-low.
- Reset values:
  - all vji_* outputs 0; vji_tck is low
  - cmd_ready 1, rsp_valid 0, rsp_data 0
  - FSM in IDLE, divider 0
- tck generation:
  - Divider counts 0..TCK_DIV-1 and toggles vji_tck at terminal count, but only while the FSM is not IDLE/DONE.
  - A tck period is 2*TCK_DIV clk cycles. tck starts low.
  - "rise" is the clk edge that sets vji_tck to 1; "fall" is the clk edge that clears it.
- FSM: IDLE → UIR → CDR → SDR → UDR → RTI → DONE → IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
    - latch cmd_ir into vji_ir_in (held until the next accept)
    - latch cmd_data into the tx shift register
    - cmd_ready=0, enter UIR
  - Each state flag (vji_uir/cdr/sdr/udr/rti) is asserted in its own state only, changes only on a fall edge (or at entry from IDLE), and is held across that state's rises.
  - UIR: 1 tck period. CDR: 1 period.
  - SDR: DR_WIDTH periods.
    - vji_tdi = tx[0] throughout the period.
    - On each rise: rx <= {vji_tdo, rx[DR_WIDTH-1:1]}. On each fall: tx >>= 1.
  - UDR: 1 period. RTI: RTI_TCKS periods, vji_rti=1.
  - At the fall ending RTI, enter DONE; tck stays low.
  - DONE: rsp_data<=rx, rsp_valid=1 for exactly one cycle, then IDLE with cmd_ready=1.
- Latency:
  - N_TCK = 3 + DR_WIDTH + RTI_TCKS (43 with defaults).
  - Accept at edge k → rsp_valid high in cycle k+1+2*TCK_DIV*N_TCK (173 with defaults).
  - Next accept is possible the cycle after rsp_valid.
- Boundary conditions:
  - cmd_valid while busy is ignored; the requester holds it.
  - cmd_valid held across DONE starts a new transaction on the first IDLE cycle.
  - Reset mid-transaction: next edge forces reset values. No partial rsp is issued. tck is low immediately; any half-sampled bit is discarded.
  - vji_sdr never overlaps vji_cdr or vji_udr. Exactly DR_WIDTH rises occur with vji_sdr=1.
  - vji_tdo is sampled only on SDR rises; the tdo level in other states is ignored.

Decomposition:
- Package easy_cpu_debug_jtag_pkg:
  - FSM state enum
  - IR code constants (IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL)
  - N_TCK derivation
- Sub-module easy_cpu_debug_tck_gen:
  - divider plus tck register
  - emits rise/fall one-cycle strobes and takes a run enable
- FSM, shift registers and command/response handshake live in the top.

Test Plan:
- Bench slave model: 38-bit sr; cdr loads 38'h2A_1234_5678; sdr shifts sr <= {tdi, sr[37:1]} on tck rise; tdo = sr[0]; udr copies sr to a jdo register.
- Default params, cmd_ir=2'b10, cmd_data=38'h15_DEAD_BEEF → rsp_data=38'h2A_1234_5678, model jdo=38'h15_DEAD_BEEF, model ir_in=2'b10, rsp_valid exactly 173 cycles after accept.
- Strobe-count checker → per transaction: one rise each under uir/cdr/udr, 38 under sdr, 2 under rti; flags mutually exclusive; tck low in IDLE.
- cmd_valid held high for 3 back-to-back commands (data 0, all-ones, 38'h1) → cmd_ready low while busy; rsp of each equals the previous command's data when the model's cdr reloads jdo; no overlap between transactions.
- reset_n low for 1 cycle at accept+60 → all outputs at reset values next cycle, no rsp_valid; a subsequent command completes correctly.
- TCK_DIV=1, RTI_TCKS=1 build → tck period 2 clk, rsp_valid at accept+1+2*42=85; data integrity as in the first scenario.
